axi_10g_ethernet_0_tx_frame_fifo: RTL and testbench

- Store-and-forward TX frame buffer directly upstream of the 10G MAC's 32-bit s_axis_tx interface.
- Accepts frames from the host-side AXI-Stream and releases a frame to the MAC only after it is fully stored and marked good. The MAC therefore never sees a tvalid gap mid-frame, which would cause an underrun.
- Frames flagged bad, or frames that overflow the buffer, are discarded whole and counted.

---
 rtl/axi_10g_ethernet_0_tx_frame_fifo_if.sv | 26 ++
 rtl/axi_10g_ethernet_0_tx_frame_fifo.sv | 184 ++++++++++++++++++
 tb/tb_axi_10g_ethernet_0_tx_frame_fifo.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_10g_ethernet_0_tx_frame_fifo_if.sv
// ---------------------------------------------------------------------------
// axi_10g_ethernet_0_tx_frame_fifo_if
// 32-bit AXI-Stream bundle used on both sides of the TX frame FIFO.
//   tdata  : 32-bit beat data
//   tkeep  : byte enables, contiguous from bit 0
//   tvalid : source has a beat
//   tlast  : final beat of a frame
//   tuser  : sideband; on the upstream side 1 on the tlast beat = bad frame
//   tready : sink accepts the beat
// A beat transfers on a rising clock edge where tvalid and tready are both 1.
// The source holds tdata/tkeep/tlast/tuser stable while tvalid=1 and
// tready=0, and does not drop tvalid until the beat has transferred.
// ---------------------------------------------------------------------------
interface axi_10g_ethernet_0_tx_frame_fifo_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast,
                  output tuser, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast,
                  input tuser, output tready);
endinterface

// File: rtl/axi_10g_ethernet_0_tx_frame_fifo.sv
// ---------------------------------------------------------------------------
// axi_10g_ethernet_0_tx_frame_fifo
// Store-and-forward TX frame buffer in front of the 10G MAC 32-bit TX port.
// A frame becomes visible to the MAC only once its good tlast has been
// written, so the MAC never sees a tvalid gap inside a frame. Bad frames and
// frames that do not fit are discarded whole and counted.
//
// Ports
//   coreclk        : clock, all logic in this domain
//   reset          : synchronous, active-high
//   s_axis         : upstream AXI-Stream (slave); tready=1 whenever not in reset
//   m_axis_tx      : to MAC s_axis_tx (master); tuser tied 0
//   frames_stored  : committed frames not yet fully sent
//   frames_dropped : wrapping count of discarded frames
//   overflow_pulse : one-cycle pulse when a frame is dropped for lack of space
//   wr_state_dbg   : write FSM state (0 IDLE, 1 WRITE, 2 DROP)
//   rd_state_dbg   : read FSM state (0 IDLE, 1 STREAM)
//
// Handshake: a beat moves on a rising edge where tvalid & tready are 1; the
// output holds data/keep/last and tvalid while tready=0.
// ---------------------------------------------------------------------------
module axi_10g_ethernet_0_tx_frame_fifo #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                                      coreclk,
  input  logic                                      reset,
  axi_10g_ethernet_0_tx_frame_fifo_if.slave         s_axis,
  axi_10g_ethernet_0_tx_frame_fifo_if.master        m_axis_tx,
  output logic [ADDR_WIDTH:0]                       frames_stored,
  output logic [31:0]                               frames_dropped,
  output logic                                      overflow_pulse,
  output logic [1:0]                                wr_state_dbg,
  output logic                                      rd_state_dbg
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_WRITE = 2'd1, WR_DROP = 2'd2} wr_state_t;
  typedef enum logic       {RD_IDLE = 1'b0, RD_STREAM = 1'b1} rd_state_t;

  // Memory word: {last, keep[3:0], data[31:0]}
  logic [36:0]   r_mem [DEPTH];

  wr_state_t     r_wr_state, w_wr_state_nxt;
  rd_state_t     r_rd_state, w_rd_state_nxt;
  logic [PW-1:0] r_wr_ptr, w_wr_ptr_nxt;
  logic [PW-1:0] r_wr_commit, w_wr_commit_nxt;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] w_occupancy;
  logic          w_full, w_accept, w_we, w_commit, w_drop, w_ovf;

  // Two-stage read pipeline: stage A is the synchronous memory read
  // (prefetch), stage B is the output register seen by the MAC.
  logic [36:0]   r_a_word, r_b_word;
  logic          r_a_valid, r_b_valid;
  logic          w_out_ready, w_b_load, w_rd_en, w_rd_issue, w_last_hs;

  logic [PW-1:0] r_frames_stored;
  logic [31:0]   r_frames_dropped;
  logic          r_ovf;

  assign s_axis.tready = ~reset;
  assign w_accept      = s_axis.tvalid & s_axis.tready;
  assign w_occupancy   = r_wr_ptr - r_rd_ptr;
  assign w_full        = (w_occupancy == PW'(DEPTH));

  // Write FSM: next state, pointer updates, commit/drop strobes
  always_comb begin
    w_wr_state_nxt  = r_wr_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_wr_commit_nxt = r_wr_commit;
    w_we            = 1'b0;
    w_commit        = 1'b0;
    w_drop          = 1'b0;
    w_ovf           = 1'b0;
    case (r_wr_state)
      WR_IDLE, WR_WRITE: begin
        if (w_accept) begin
          if (w_full) begin
            // No room: rewind to the last commit point, discard the rest.
            w_wr_ptr_nxt   = r_wr_commit;
            w_drop         = 1'b1;
            w_ovf          = 1'b1;
            w_wr_state_nxt = s_axis.tlast ? WR_IDLE : WR_DROP;
          end else begin
            w_we           = 1'b1;
            w_wr_ptr_nxt   = r_wr_ptr + PW'(1);
            w_wr_state_nxt = WR_WRITE;
            if (s_axis.tlast) begin
              w_wr_state_nxt = WR_IDLE;
              if (s_axis.tuser) begin
                w_wr_ptr_nxt = r_wr_commit;
                w_drop       = 1'b1;
              end else begin
                w_wr_commit_nxt = r_wr_ptr + PW'(1);
                w_commit        = 1'b1;
              end
            end
          end
        end
      end
      WR_DROP: begin
        if (w_accept && s_axis.tlast) w_wr_state_nxt = WR_IDLE;
      end
      default: w_wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read side: words below wr_commit belong to complete good frames only.
  assign w_out_ready = ~r_b_valid | m_axis_tx.tready;
  assign w_b_load    = r_a_valid & w_out_ready;
  assign w_rd_en     = (r_rd_state == RD_STREAM) | (r_frames_stored != '0);
  assign w_rd_issue  = w_rd_en & (r_rd_ptr != r_wr_commit) & (~r_a_valid | w_out_ready);
  assign w_last_hs   = r_b_valid & m_axis_tx.tready & r_b_word[36];

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE:   if (r_frames_stored != '0) w_rd_state_nxt = RD_STREAM;
      RD_STREAM: if (w_last_hs && !w_commit && r_frames_stored == PW'(1))
                   w_rd_state_nxt = RD_IDLE;
      default:   w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Storage and prefetch read; contents need no reset since the pointers
  // decide what is valid.
  always_ff @(posedge coreclk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    if (w_rd_issue) r_a_word <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge coreclk) begin
    if (reset) begin
      r_wr_state       <= WR_IDLE;
      r_rd_state       <= RD_IDLE;
      r_wr_ptr         <= '0;
      r_wr_commit      <= '0;
      r_rd_ptr         <= '0;
      r_a_valid        <= 1'b0;
      r_b_valid        <= 1'b0;
      r_b_word         <= '0;
      r_frames_stored  <= '0;
      r_frames_dropped <= '0;
      r_ovf            <= 1'b0;
    end else begin
      r_wr_state  <= w_wr_state_nxt;
      r_rd_state  <= w_rd_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_wr_commit <= w_wr_commit_nxt;
      r_ovf       <= w_ovf;
      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_rd_issue)    r_a_valid <= 1'b1;
      else if (w_b_load) r_a_valid <= 1'b0;
      if (w_b_load) begin
        r_b_word  <= r_a_word;
        r_b_valid <= 1'b1;
      end else if (m_axis_tx.tready) begin
        r_b_valid <= 1'b0;
      end
      // Commit and final-beat handshake in the same cycle cancel out.
      case ({w_commit, w_last_hs})
        2'b10:   r_frames_stored <= r_frames_stored + PW'(1);
        2'b01:   r_frames_stored <= r_frames_stored - PW'(1);
        default: r_frames_stored <= r_frames_stored;
      endcase
      if (w_drop) r_frames_dropped <= r_frames_dropped + 32'd1;
    end
  end

  assign m_axis_tx.tdata  = r_b_word[31:0];
  assign m_axis_tx.tkeep  = r_b_word[35:32];
  assign m_axis_tx.tlast  = r_b_word[36];
  assign m_axis_tx.tvalid = r_b_valid;
  assign m_axis_tx.tuser  = 1'b0;

  assign frames_stored  = r_frames_stored;
  assign frames_dropped = r_frames_dropped;
  assign overflow_pulse = r_ovf;
  assign wr_state_dbg   = r_wr_state;
  assign rd_state_dbg   = r_rd_state;

endmodule

// File: tb/tb_axi_10g_ethernet_0_tx_frame_fifo.sv
module tb_axi_10g_ethernet_0_tx_frame_fifo;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_10g_ethernet_0_tx_frame_fifo_if s_if();
  axi_10g_ethernet_0_tx_frame_fifo_if m_if();

  logic [AW:0]  frames_stored;
  logic [31:0]  frames_dropped;
  logic         overflow_pulse;
  logic [1:0]   wr_state_dbg;
  logic         rd_state_dbg;

  axi_10g_ethernet_0_tx_frame_fifo #(.ADDR_WIDTH(AW)) u_dut (
    .coreclk        (clk),
    .reset          (rst),
    .s_axis         (s_if),
    .m_axis_tx      (m_if),
    .frames_stored  (frames_stored),
    .frames_dropped (frames_dropped),
    .overflow_pulse (overflow_pulse),
    .wr_state_dbg   (wr_state_dbg),
    .rd_state_dbg   (rd_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests     = 0;
  int          n_fail      = 0;
  logic [36:0] exp_q[$];
  int          exp_dropped = 0;
  int          rdy_mode    = 0;  // 0 high, 1 toggle, 2 random, 3 low
  int          out_beats   = 0;
  logic [3:0]  keep_tab [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MAC-side ready generator
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ~m_if.tready;
      2:       m_if.tready = ($urandom_range(0, 1) == 1);
      default: m_if.tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard pop, hold-stability and no-gap checks
  logic        prev_stall = 1'b0;
  logic        in_frame   = 1'b0;
  logic [36:0] prev_word;
  logic [36:0] mon_word;
  logic [36:0] mon_exp;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end else begin
      mon_word = {m_if.tlast, m_if.tkeep, m_if.tdata};
      if (prev_stall) begin
        check("hold_valid", 64'(m_if.tvalid), 64'(1));
        check("hold_word", 64'(mon_word), 64'(prev_word));
      end
      if (in_frame) check("no_gap", 64'(m_if.tvalid), 64'(1));
      if (m_if.tvalid && m_if.tready) begin
        check("q_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("beat", 64'(mon_word), 64'(mon_exp));
        end
        out_beats++;
        in_frame = !m_if.tlast;
      end else if (m_if.tvalid) begin
        in_frame = 1'b1;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_word  = mon_word;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame beat per cycle; kept frames are pushed to the scoreboard.
  // ovf_beat < 0 skips the overflow_pulse check.
  task automatic send_frame(input int len, input bit bad, input logic [3:0] last_keep,
                            input bit kept, input int ovf_beat);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d           = $urandom;
      s_if.tdata  = d;
      s_if.tkeep  = (i == len - 1) ? last_keep : 4'hf;
      s_if.tlast  = (i == len - 1);
      s_if.tuser  = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
      s_if.tvalid = 1'b1;
      if (kept) exp_q.push_back({s_if.tlast, s_if.tkeep, d});
      step(1);
      if (ovf_beat >= 0) check("ovf_pulse", 64'(overflow_pulse), 64'(i + 1 == ovf_beat));
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || frames_stored != '0 || m_if.tvalid) && c < budget) begin
      step(1);
      c++;
    end
    check("drain_in_budget", 64'(c < budget), 64'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int c;
    int sent;
    int committed;
    int nb;
    int len;
    bit bad;
    bit kept;
    int tries;

    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
    rdy_mode    = 3;
    rst         = 1'b1;
    step(3);

    // Reset state
    check("rst_s_tready", 64'(s_if.tready), 64'(0));
    check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_tlast", 64'(m_if.tlast), 64'(0));
    check("rst_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_tkeep", 64'(m_if.tkeep), 64'(0));
    check("rst_stored", 64'(frames_stored), 64'(0));
    check("rst_dropped", 64'(frames_dropped), 64'(0));
    check("rst_ovf", 64'(overflow_pulse), 64'(0));
    check("rst_wr_state", 64'(wr_state_dbg), 64'(0));
    check("rst_rd_state", 64'(rd_state_dbg), 64'(0));
    rst = 1'b0;
    rdy_mode = 0;
    step(1);
    check("s_tready_after_rst", 64'(s_if.tready), 64'(1));

    // Single 16-beat frame; first output beat two edges after the tlast edge
    base = out_beats;
    send_frame(16, 1'b0, 4'b0011, 1'b1, -1);
    check("t1_stored", 64'(frames_stored), 64'(1));
    check("t1_lat_e0", 64'(m_if.tvalid), 64'(0));
    step(1);
    check("t1_lat_e1", 64'(m_if.tvalid), 64'(0));
    step(1);
    check("t1_lat_e2", 64'(m_if.tvalid), 64'(1));
    wait_drain(200);
    check("t1_stored_end", 64'(frames_stored), 64'(0));
    check("t1_beats", 64'(out_beats - base), 64'(16));

    // Bad 10-beat frame followed by a good 4-beat frame
    base = out_beats;
    send_frame(10, 1'b1, 4'hf, 1'b0, -1);
    exp_dropped++;
    send_frame(4, 1'b0, 4'b0111, 1'b1, -1);
    wait_drain(200);
    check("t2_dropped", 64'(frames_dropped), 64'(exp_dropped));
    check("t2_beats", 64'(out_beats - base), 64'(4));

    // Frame larger than the buffer: overflow on the first beat that does not fit
    base = out_beats;
    send_frame(DEPTH + 6, 1'b0, 4'hf, 1'b0, DEPTH + 1);
    exp_dropped++;
    step(4);
    check("t3_dropped", 64'(frames_dropped), 64'(exp_dropped));
    check("t3_no_output", 64'(out_beats - base), 64'(0));
    check("t3_stored", 64'(frames_stored), 64'(0));
    send_frame(8, 1'b0, 4'b0001, 1'b1, 0);
    wait_drain(200);
    check("t3_beats", 64'(out_beats - base), 64'(8));

    // Three back-to-back 5-beat frames with MAC ready toggling
    base = out_beats;
    rdy_mode = 1;
    for (int f = 0; f < 3; f++) send_frame(5, 1'b0, keep_tab[f], 1'b1, -1);
    wait_drain(300);
    rdy_mode = 0;
    check("t4_beats", 64'(out_beats - base), 64'(15));

    // Reset during the third output beat of an 8-beat frame
    send_frame(8, 1'b0, 4'hf, 1'b1, -1);
    c = 0;
    while (!m_if.tvalid && c < 20) begin
      step(1);
      c++;
    end
    check("t5_valid_seen", 64'(m_if.tvalid), 64'(1));
    step(2);
    rst = 1'b1;
    step(1);
    check("t5_tvalid", 64'(m_if.tvalid), 64'(0));
    check("t5_stored", 64'(frames_stored), 64'(0));
    check("t5_dropped", 64'(frames_dropped), 64'(0));
    check("t5_s_tready", 64'(s_if.tready), 64'(0));
    exp_q.delete();
    exp_dropped = 0;
    rst = 1'b0;
    step(1);
    base = out_beats;
    send_frame(6, 1'b0, 4'b0011, 1'b1, -1);
    wait_drain(200);
    check("t5_after_beats", 64'(out_beats - base), 64'(6));

    // Random batches across the pointer wrap. The MAC is stalled while a batch
    // is written so space is predictable: up to 2 words may already have been
    // prefetched out, so lengths landing in that 2-word window are re-rolled.
    sent = 0;
    while (sent < 300) begin
      rdy_mode  = 3;
      committed = 0;
      nb        = $urandom_range(1, 6);
      for (int b = 0; b < nb && sent < 300; b++) begin
        bad   = ($urandom_range(0, 5) == 0);
        len   = $urandom_range(1, 64);
        tries = 0;
        while (!bad && committed + len > DEPTH && committed + len <= DEPTH + 2 && tries < 200) begin
          len = $urandom_range(1, 64);
          tries++;
        end
        kept = !bad && (committed + len <= DEPTH);
        send_frame(len, bad, keep_tab[$urandom_range(0, 3)], kept, -1);
        if (kept) committed += len;
        else      exp_dropped++;
        sent++;
        step($urandom_range(0, 2));
      end
      rdy_mode = 2;
      wait_drain(5000);
    end
    rdy_mode = 0;
    check("t6_dropped", 64'(frames_dropped), 64'(exp_dropped));
    check("t6_stored", 64'(frames_stored), 64'(0));
    check("t6_q_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
